mul_div_unit: RTL

Execute-stage multiply/divide unit for the P7 five-stage MIPS core, operating alongside the ALU on the same forwarded operands (SA, SB). It runs a fixed-latency multi-cycle operation (mult/multu/div/divu) and owns the HI/LO registers. It serves mfhi/mflo/mthi/mtlo, and drives Busy so hazard logic can stall dependent MDU instructions. It honours the exception/interrupt request (Req) so that a flushed E-stage instruction never commits.

---
 rtl/mul_div_unit_pkg.sv | 24 ++
 rtl/mul_div_unit_core.sv | 46 ++++
 rtl/mul_div_unit.sv | 79 +++++++
 3 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared MDU opcode encodings and default latencies, used by the controller
// decode and by the multiply/divide unit.
package mul_div_unit_pkg;
  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MFHI  = 4'd5;
  localparam logic [3:0] MDU_MFLO  = 4'd6;
  localparam logic [3:0] MDU_MTHI  = 4'd7;
  localparam logic [3:0] MDU_MTLO  = 4'd8;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic is_long_op(input logic [3:0] op);
    return (op >= MDU_MULT) && (op <= MDU_DIVU);
  endfunction

  function automatic logic is_mult_op(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction
endpackage

// File: rtl/mul_div_unit_core.sv
// Combinational datapath: 64-bit {hi,lo} result for the latched op and operands.
// o_wr is low for a divide by zero so HI/LO are preserved.
module mdu_core
  import mul_div_unit_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [3:0]  i_op,
  output logic [63:0] o_res,
  output logic        o_wr
);
  logic        w_zero;
  logic [31:0] w_den_u, w_mag_a, w_mag_b, w_uq, w_ur, w_sq, w_sr;
  logic [63:0] w_prod_s, w_prod_u;

  assign w_zero   = (i_b == 32'd0);
  assign w_prod_s = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
  assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

  // Signed divide works on magnitudes; |0x80000000| is representable unsigned,
  // which makes the INT_MIN / -1 case fall out as quotient 0x80000000.
  assign w_mag_a = i_a[31] ? (~i_a + 32'd1) : i_a;
  assign w_mag_b = i_b[31] ? (~i_b + 32'd1) : i_b;
  assign w_den_u = w_zero ? 32'd1 : i_b;

  logic [31:0] w_den_s, w_mq, w_mr;
  assign w_den_s = w_zero ? 32'd1 : w_mag_b;
  assign w_mq    = w_mag_a / w_den_s;
  assign w_mr    = w_mag_a % w_den_s;
  assign w_sq    = (i_a[31] ^ i_b[31]) ? (~w_mq + 32'd1) : w_mq;
  assign w_sr    = i_a[31] ? (~w_mr + 32'd1) : w_mr;
  assign w_uq    = i_a / w_den_u;
  assign w_ur    = i_a % w_den_u;

  always_comb begin
    o_res = 64'd0;
    o_wr  = 1'b0;
    case (i_op)
      MDU_MULT:  begin o_res = w_prod_s;     o_wr = 1'b1;    end
      MDU_MULTU: begin o_res = w_prod_u;     o_wr = 1'b1;    end
      MDU_DIV:   begin o_res = {w_sr, w_sq}; o_wr = !w_zero; end
      MDU_DIVU:  begin o_res = {w_ur, w_uq}; o_wr = !w_zero; end
      default:   begin o_res = 64'd0;        o_wr = 1'b0;    end
    endcase
  end
endmodule

// File: rtl/mul_div_unit.sv
// E-stage multiply/divide unit: fixed-latency FSM, HI/LO ownership and
// mfhi/mflo/mthi/mtlo service. A flushed (Req) E instruction never commits.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] SA,
  input  logic [31:0] SB,
  input  logic [3:0]  MDUOp,
  input  logic        Start,
  input  logic        Req,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUOut
);
  localparam logic IDLE = 1'b0;
  localparam logic RUN  = 1'b1;

  logic        r_state;
  logic [3:0]  r_cnt, r_op;
  logic [31:0] r_a, r_b, r_hi, r_lo;
  logic [63:0] w_res;
  logic        w_wr, w_start;

  mdu_core u_core (
    .i_a  (r_a),
    .i_b  (r_b),
    .i_op (r_op),
    .o_res(w_res),
    .o_wr (w_wr)
  );

  assign w_start = Start && is_long_op(MDUOp) && !Req && (r_state == IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_op    <= MDU_NONE;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else if (r_state == IDLE) begin
      if (w_start) begin
        r_state <= RUN;
        r_a     <= SA;
        r_b     <= SB;
        r_op    <= MDUOp;
        r_cnt   <= is_mult_op(MDUOp) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
      end else if (!Req) begin
        if (MDUOp == MDU_MTHI) r_hi <= SA;
        if (MDUOp == MDU_MTLO) r_lo <= SA;
      end
    end else begin
      // Req is deliberately ignored here: the running op is already committed.
      r_cnt <= r_cnt - 4'd1;
      if (r_cnt == 4'd1) begin
        r_state <= IDLE;
        if (w_wr) {r_hi, r_lo} <= w_res;
      end
    end
  end

  assign Busy = (r_state == RUN);
  assign HI   = r_hi;
  assign LO   = r_lo;

  always_comb begin
    MDUOut = 32'd0;
    if (MDUOp == MDU_MFHI) MDUOut = r_hi;
    else if (MDUOp == MDU_MFLO) MDUOut = r_lo;
  end
endmodule
